// File: rtl/string_receiver_pkg.sv
// Shared WS2812B timing constants, FSM encodings and helpers for the string receiver.
`timescale 1ns / 1ps
package string_receiver_pkg;

  // Line timing in ns, shared with the transmitter side of the link.
  localparam int unsigned DefClkPeriodNs = 100;
  localparam int unsigned SplitNs        = 650;
  localparam int unsigned BitMaxNs       = 2000;
  localparam int unsigned BlankNs        = 40000;

  // Datapath widths.
  localparam int unsigned LenWidth    = 10;
  localparam int unsigned PixelWidth  = 24;
  localparam int unsigned BitCntWidth = 5;
  localparam int unsigned CountWidth  = 16;

  // Receiver FSM encodings.
  localparam logic [1:0] StIdleHigh = 2'd0;
  localparam logic [1:0] StLow      = 2'd1;
  localparam logic [1:0] StBlank    = 2'd2;

  // Meaning of a completed low phase.
  typedef enum logic [1:0] {
    LowOne,
    LowZero,
    LowError
  } low_class_e;

  // Round a duration in ns up to whole clock cycles.
  function automatic int unsigned get_count(input int unsigned ns, input int unsigned period_ns);
    return (ns + period_ns - 1) / period_ns;
  endfunction

  // Classify a low-phase width (cycles) that ended before the blank threshold.
  function automatic low_class_e classify_low(input logic [LenWidth-1:0] len,
                                              input logic [LenWidth-1:0] split,
                                              input logic [LenWidth-1:0] bit_max);
    if (len <= split) begin
      return LowOne;
    end
    if (len <= bit_max) begin
      return LowZero;
    end
    return LowError;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
`timescale 1ns / 1ps
module sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability-settling chain; both stages preset so an idle-high line looks idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/string_receiver.sv
// WS2812B serial receiver: decodes bits from low-phase widths, assembles 24-bit pixels,
// detects blanking gaps and flags illegal low widths.
`timescale 1ns / 1ps
module string_receiver
  import string_receiver_pkg::*;
#(
  parameter int unsigned CLK_PERIOD_NS = DefClkPeriodNs,
  parameter int unsigned kSplit_ns     = SplitNs,
  parameter int unsigned kBitMax_ns    = BitMaxNs,
  parameter int unsigned kBlank_ns     = BlankNs
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sdi,
  output logic [PixelWidth-1:0] pixel_data,
  output logic                  pixel_data_valid,
  output logic                  h_blank,
  output logic                  frame_error,
  output logic [CountWidth-1:0] pixel_count
);

  localparam int unsigned KSplit  = get_count(kSplit_ns, CLK_PERIOD_NS);
  localparam int unsigned KBitMax = get_count(kBitMax_ns, CLK_PERIOD_NS);
  localparam int unsigned KBlank  = get_count(kBlank_ns, CLK_PERIOD_NS);

  localparam logic [LenWidth-1:0]    LSplit    = LenWidth'(KSplit);
  localparam logic [LenWidth-1:0]    LBitMax   = LenWidth'(KBitMax);
  localparam logic [LenWidth-1:0]    LBlank    = LenWidth'(KBlank);
  localparam logic [LenWidth-1:0]    LBlankM1  = LenWidth'(KBlank - 1);
  localparam logic [BitCntWidth-1:0] LastBit   = BitCntWidth'(PixelWidth - 1);

  // Synchronized line and edge detection.
  logic sdi_sync;
  logic sdi_dly_q;
  // Marks which pipeline stages hold genuinely sampled data rather than reset presets.
  logic [2:0] live_q;
  logic       fall;
  logic       rise;

  logic [1:0]             state_q, state_d;
  logic [LenWidth-1:0]    len_q, len_d;
  logic [PixelWidth-1:0]  shift_q, shift_d;
  logic [BitCntWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic                   pend_q, pend_d;
  logic [PixelWidth-1:0]  pixel_q, pixel_d;
  logic                   valid_q, valid_d;
  logic                   blank_q, blank_d;
  logic                   err_q, err_d;
  logic [CountWidth-1:0]  count_q, count_d;
  low_class_e             low_class;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sdi_sync (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (sdi),
    .q_o  (sdi_sync)
  );

  // Edge-detect delay flop plus liveness tracking of the synchronizer pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdi_dly_q <= 1'b1;
      live_q    <= 3'b000;
    end else begin
      sdi_dly_q <= sdi_sync;
      live_q    <= {live_q[1:0], 1'b1};
    end
  end

  // A fall only counts once the delayed sample is real, so a line held low across
  // reset release is treated as mid-pulse rather than a fresh bit.
  assign fall = live_q[2] & sdi_dly_q & ~sdi_sync;
  assign rise = ~sdi_dly_q & sdi_sync;

  // Bit decoding FSM: measures the low phase and shifts decoded bits in MSB first.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pend_d    = 1'b0;
    blank_d   = 1'b0;
    err_d     = 1'b0;
    low_class = classify_low(len_q, LSplit, LBitMax);

    case (state_q)
      StIdleHigh: begin
        if (fall) begin
          state_d = StLow;
          len_d   = LenWidth'(1);
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StIdleHigh;
          if (low_class == LowError) begin
            err_d     = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
          end else begin
            shift_d = {shift_q[PixelWidth-2:0], low_class == LowOne};
            if (bit_cnt_q == LastBit) begin
              bit_cnt_d = '0;
              pend_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BitCntWidth'(1);
            end
          end
        end else if (len_q >= LBlankM1) begin
          // Counter saturates at the blank threshold; BLANK never advances it.
          len_d     = LBlank;
          blank_d   = 1'b1;
          shift_d   = '0;
          bit_cnt_d = '0;
          state_d   = StBlank;
        end else begin
          len_d = len_q + LenWidth'(1);
        end
      end
      StBlank: begin
        if (rise) begin
          state_d = StIdleHigh;
        end
      end
      default: begin
        state_d = StIdleHigh;
      end
    endcase
  end

  // Output stage: publishes a completed pixel one cycle after its last bit is shifted in.
  always_comb begin
    pixel_d = pixel_q;
    valid_d = 1'b0;
    count_d = count_q;
    if (pend_q) begin
      pixel_d = shift_q;
      valid_d = 1'b1;
      if (count_q != {CountWidth{1'b1}}) begin
        count_d = count_q + CountWidth'(1);
      end
    end
    if (blank_d) begin
      count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdleHigh;
      len_q     <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      pend_q    <= 1'b0;
      pixel_q   <= '0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      pend_q    <= pend_d;
      pixel_q   <= pixel_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign pixel_data       = pixel_q;
  assign pixel_data_valid = valid_q;
  assign h_blank          = blank_q;
  assign frame_error      = err_q;
  assign pixel_count      = count_q;

endmodule

// File: tb/tb_string_receiver.sv
// Directed, self-checking bench for string_receiver with a pixel scoreboard.
`timescale 1ns / 1ps
module tb_string_receiver;

  logic        clk;
  logic        rst;
  logic        sdi;
  logic [23:0] pixel_data;
  logic        pixel_data_valid;
  logic        h_blank;
  logic        frame_error;
  logic [15:0] pixel_count;

  int tests_run;
  int tests_failed;

  // Scoreboard: expected pixels pushed by stimulus, observed pixels logged by the monitor.
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          obs_rd;

  int n_valid;
  int n_blank;
  int n_err;
  int n_overlap;

  string_receiver u_dut (
    .clk             (clk),
    .rst             (rst),
    .sdi             (sdi),
    .pixel_data      (pixel_data),
    .pixel_data_valid(pixel_data_valid),
    .h_blank         (h_blank),
    .frame_error     (frame_error),
    .pixel_count     (pixel_count)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (pixel_data_valid) begin
      n_valid++;
      obs_q.push_back(pixel_data);
    end
    if (h_blank) n_blank++;
    if (frame_error) n_err++;
    if ((2'(pixel_data_valid) + 2'(h_blank) + 2'(frame_error)) > 2'd1) n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic score(input string tag);
    check({tag, "_valid_count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (obs_rd < obs_q.size()) begin
        check({tag, "_pixel"}, {8'h00, obs_q[obs_rd]}, {8'h00, exp_q[0]});
        obs_rd++;
      end
      void'(exp_q.pop_front());
    end
    obs_rd = obs_q.size();
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transmitter-timed bit: 1 = 800 high / 450 low, 0 = 400 high / 850 low.
  task automatic bit_ns(input logic b);
    sdi = 1'b1;
    if (b) #800;
    else #400;
    sdi = 1'b0;
    if (b) #450;
    else #850;
  endtask

  task automatic pixel_ns(input logic [23:0] p, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) bit_ns(p[i]);
    sdi = 1'b1;
  endtask

  // Clock-aligned bit with a low phase of exactly low_w sampled cycles.
  task automatic bit_cyc(input int low_w);
    sdi = 1'b1;
    cyc_wait(5);
    sdi = 1'b0;
    cyc_wait(low_w);
    sdi = 1'b1;
  endtask

  initial begin
    int          lat;
    int          b_valid;
    int          b_blank;
    int          b_err;
    logic [23:0] p2;
    logic [20:0] tail;

    tests_run    = 0;
    tests_failed = 0;
    obs_rd       = 0;
    n_valid      = 0;
    n_blank      = 0;
    n_err        = 0;
    n_overlap    = 0;

    // Reset with the line held low so release happens mid-pulse.
    rst = 1'b1;
    sdi = 1'b0;
    cyc_wait(4);
    check("rst_pixel_data", {8'h00, pixel_data}, 32'h0);
    check("rst_valid", {31'b0, pixel_data_valid}, 32'h0);
    check("rst_h_blank", {31'b0, h_blank}, 32'h0);
    check("rst_frame_error", {31'b0, frame_error}, 32'h0);
    check("rst_pixel_count", {16'h0, pixel_count}, 32'h0);
    rst = 1'b0;
    cyc_wait(10);
    sdi = 1'b1;
    cyc_wait(5);

    // First pixel with transmitter timing.
    b_err = n_err;
    exp_q.push_back(24'hA5C30F);
    pixel_ns(24'hA5C30F, 24);
    cyc_wait(10);
    score("px_a5c30f");
    check("px_a5c30f_count", {16'h0, pixel_count}, 32'd1);
    check("px_a5c30f_no_err", 32'(n_err - b_err), 32'd0);

    // Second pixel, clock-aligned, to measure valid latency from the final rise.
    p2 = 24'h3C5A96;
    exp_q.push_back(p2);
    for (int i = 23; i >= 0; i--) bit_cyc(p2[i] ? 4 : 10);
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (pixel_data_valid) begin
        lat = k - 1;
        break;
      end
    end
    check("valid_latency", 32'(lat), 32'd3);
    @(posedge clk);
    #1;
    check("valid_one_cycle", {31'b0, pixel_data_valid}, 32'h0);
    cyc_wait(5);
    score("px_3c5a96");
    check("px_3c5a96_count", {16'h0, pixel_count}, 32'd2);

    // Blank: hold low 50 us; h_blank lands 400 cycles after the synchronized fall,
    // i.e. 401 edges after the edge that first samples the line low.
    b_valid = n_valid;
    b_blank = n_blank;
    b_err   = n_err;
    sdi     = 1'b0;
    lat     = -1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      if (h_blank) begin
        lat = k - 1;
        break;
      end
    end
    check("blank_latency", 32'(lat), 32'd401);
    cyc_wait(99);
    check("blank_pixel_count", {16'h0, pixel_count}, 32'd0);
    sdi = 1'b1;
    cyc_wait(10);
    check("blank_once", 32'(n_blank - b_blank), 32'd1);
    check("blank_no_valid", 32'(n_valid - b_valid), 32'd0);
    check("blank_no_err", 32'(n_err - b_err), 32'd0);
    check("blank_pixel_hold", {8'h00, pixel_data}, 32'h003C5A96);

    // Frame error: 10 bits then a 3 us low, then a clean pixel.
    b_valid = n_valid;
    b_err   = n_err;
    pixel_ns(24'h6B4000, 10);
    #400;
    sdi = 1'b0;
    #3000;
    sdi = 1'b1;
    cyc_wait(10);
    check("ferr_once", 32'(n_err - b_err), 32'd1);
    check("ferr_no_valid", 32'(n_valid - b_valid), 32'd0);
    exp_q.push_back(24'h5A17E3);
    pixel_ns(24'h5A17E3, 24);
    cyc_wait(10);
    score("ferr_recover");
    check("ferr_recover_count", {16'h0, pixel_count}, 32'd1);

    // Width boundaries: 7 -> 1, 8 -> 0, 20 -> 0, then 21 -> frame error.
    b_err = n_err;
    tail  = 21'h15A5A5;
    exp_q.push_back({3'b100, tail});
    bit_cyc(7);
    bit_cyc(8);
    bit_cyc(20);
    for (int i = 20; i >= 0; i--) bit_cyc(tail[i] ? 4 : 12);
    cyc_wait(8);
    score("width_edges");
    check("width_edges_no_err", 32'(n_err - b_err), 32'd0);
    check("width_edges_count", {16'h0, pixel_count}, 32'd2);
    bit_cyc(21);
    cyc_wait(6);
    check("width_21_err", 32'(n_err - b_err), 32'd1);

    // Reset mid-pixel discards the partial pixel.
    pixel_ns(24'hFFF000, 12);
    cyc_wait(2);
    rst = 1'b1;
    cyc_wait(3);
    rst = 1'b0;
    cyc_wait(5);
    check("midrst_count", {16'h0, pixel_count}, 32'd0);
    exp_q.push_back(24'h000001);
    pixel_ns(24'h000001, 24);
    cyc_wait(10);
    score("midrst_pixel");
    check("midrst_pixel_count", {16'h0, pixel_count}, 32'd1);

    check("total_valid", 32'(n_valid), 32'd5);
    check("pulse_overlap", 32'(n_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/string_receiver.md
STRING_RECEIVER -- requirements
Module: string_receiver

Interface
REQ-001 SHALL have parameter CLK_PERIOD_NS, default 100, clk period in ns.
REQ-002 SHALL have parameter kSplit_ns, default 650, max low width (ns) decoded as bit 1.
REQ-003 SHALL have parameter kBitMax_ns, default 2000, max low width (ns) decoded as bit 0.
REQ-004 SHALL have parameter kBlank_ns, default 40000, min low width (ns) decoded as blank/reset.
REQ-005 SHALL have ports:
  clk  input  1  sole clock.
  rst  input  1  synchronous, active-high reset.
  sdi  input  1  WS2812B serial line, asynchronous to clk.
  pixel_data  output  24  last complete pixel, MSB first as received.
  pixel_data_valid  output  1  one-cycle pulse, pixel_data new.
  h_blank  output  1  one-cycle pulse, blank detected.
  frame_error  output  1  one-cycle pulse, illegal low width.
  pixel_count  output  16  complete pixels since last blank.
REQ-006 SHALL use one clock, clk; reset rst synchronous and active-high.

Function
REQ-007 SHALL pass sdi through a 2-flop synchronizer, then a third flop for edge detection; all decoding uses the synchronized signal only.
REQ-008 SHALL derive cycle counts as ceil(ns/CLK_PERIOD_NS): kSplit=7, kBitMax=20, kBlank=400 at defaults.
REQ-009 SHALL decode each bit from its low-phase width L (cycles synchronized line is low), because the line idles high and high width is unreliable.
REQ-010 SHALL implement states IDLE_HIGH (line high), LOW (counting L), BLANK (L reached kBlank, waiting for rise).
REQ-011 SHALL transition IDLE_HIGH->LOW on synchronized falling edge, clearing L to 1.
REQ-012 SHALL, in LOW on rising edge: L<=kSplit -> shift in 1; kSplit<L<=kBitMax -> shift in 0; kBitMax<L<kBlank -> frame_error pulse, discard partial pixel; then go to IDLE_HIGH.
REQ-013 SHALL, in LOW when L reaches kBlank: pulse h_blank once, discard partial pixel, clear pixel_count, go to BLANK.
REQ-014 SHALL, in BLANK, stay until rising edge, then go to IDLE_HIGH, with no further pulses.
REQ-015 SHALL use a 10-bit L counter, saturating (not wrapping) at kBlank.
REQ-016 SHALL shift bits into a 24-bit register MSB-first with a 5-bit bit counter; on the 24th bit, load pixel_data, pulse pixel_data_valid, increment pixel_count, clear the bit counter.
REQ-017 SHALL assert pixel_data_valid exactly 3 clk cycles after the first clk edge sampling sdi high at the end of the 24th low phase.
REQ-018 SHALL saturate pixel_count at 16'hFFFF.
REQ-019 SHALL hold pixel_data stable between valid pulses.
REQ-020 SHALL ensure h_blank, pixel_data_valid and frame_error are never asserted in the same cycle.

Reset
REQ-021 SHALL, on rst, set state IDLE_HIGH, synchronizer flops 1, counters 0, pixel_data 0, all pulse outputs 0, pixel_count 0.
REQ-022 SHALL treat a low line at reset release as mid-pulse: no bit decoded until a falling edge is seen after reset.
REQ-023 SHALL discard any partial pixel on rst asserted mid-pixel.

Structure
REQ-024 SHALL take the ns timing constants and the get_count round-up function from shared include string_timing.vh, also used by the transmitter.
REQ-025 SHALL instantiate a sync_2ff sub-module for the synchronizer; everything else stays in one module.

Verification
REQ-026 Bench SHALL drive pixel 0xA5C30F with transmitter timing (1: 800 high/450 low; 0: 400 high/850 low) -> one pixel_data_valid, pixel_data=0xA5C30F, pixel_count=1.
REQ-027 Bench SHALL hold sdi low 50 us after two pixels -> one h_blank exactly 400 cycles after the falling edge, pixel_count=0, no valid.
REQ-028 Bench SHALL send 10 bits then a 3 us low (30 cycles) -> one frame_error, no valid; next 24 bits -> valid with correct data.
REQ-029 Bench SHALL send low widths of 7 and 8 cycles -> decoded 1 and 0; 20 cycles -> 0; 21 cycles -> frame_error.
REQ-030 Bench SHALL assert rst after 12 bits, then send a full pixel 0x000001 -> single valid, pixel_data=0x000001.
